tile_read_sequencer: RTL and testbench

TILE_READ_SEQUENCER -- requirements
Module: tile_read_sequencer

---
 rtl/tile_pkg.sv | 12 +
 rtl/tile_lane_skew.sv | 46 ++++
 rtl/tile_read_sequencer.sv | 120 ++++++++++++
 tb/tb_tile_read_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the tile read sequencer.
//   SIZE   : default number of tile-buffer lanes
//   AW     : default per-lane read address width
//   DATA_W : width of one tile-buffer read word
//   state_t: sequencer FSM states
package tile_pkg;
  localparam int SIZE   = 8;
  localparam int AW     = 10;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/tile_lane_skew.sv
// One lane of the systolic read skew. Lane LANE reads row (t - LANE) when
// that row lies inside the tile, so each lane trails its neighbour by one
// issue slot.
//   clock, reset_n : clock, synchronous active-low reset
//   issue          : an issue slot happens this cycle (not paused)
//   t              : issue counter for this slot
//   base, len      : tile base row address and row count
//   enb, addr      : registered read enable / address for this lane
//   lane_valid     : enb delayed one cycle (read data valid)
module tile_lane_skew #(
  parameter int AW   = 10,
  parameter int TW   = 12,
  parameter int LANE = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          issue,
  input  logic [TW-1:0] t,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          enb,
  output logic [AW-1:0] addr,
  output logic          lane_valid
);

  logic [TW-1:0] off;
  logic          hit;

  // off only means something when t >= LANE; hit gates on that first
  assign off = t - TW'(LANE);
  assign hit = issue && (t >= TW'(LANE)) && (off < TW'(len));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      enb        <= 1'b0;
      addr       <= '0;
      lane_valid <= 1'b0;
    end else begin
      enb        <= hit;
      lane_valid <= enb;
      // address holds while the lane is idle or paused
      if (hit) addr <= base + off[AW-1:0];
    end
  end

endmodule

// File: rtl/tile_read_sequencer.sv
// Tile read sequencer: on an accepted start, issues L+SIZE-1 non-paused slots
// to SIZE tile-buffer lanes with a one-slot skew per lane, then drains one
// cycle with a done pulse.
//   clock, reset_n        : clock, synchronous active-low reset
//   start                 : read one tile (sampled in IDLE only)
//   base_addr, length     : tile base row and row count (latched on start)
//   pause                 : back-pressure, freezes issue
//   enb, addrb            : per-lane read enable / packed addresses
//   lane_valid            : per-lane read data valid (enb delayed 1)
//   busy, done            : in RUN/DRAIN, one-cycle completion pulse
module tile_read_sequencer
  import tile_pkg::*;
#(
  parameter int SIZE = tile_pkg::SIZE,
  parameter int AW   = tile_pkg::AW
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW:0]          length,
  input  logic                 pause,
  output logic [SIZE-1:0]      enb,
  output logic [SIZE*AW-1:0]   addrb,
  output logic [SIZE-1:0]      lane_valid,
  output logic                 busy,
  output logic                 done
);

  // counter must reach L+SIZE-1 with L up to 2^AW
  localparam int TW = AW + 2 + $clog2(SIZE);

  state_t                   state, state_nx;
  logic [TW-1:0]            t, t_nx, t_cur, t_end;
  logic [AW-1:0]            base_q, base_cur;
  logic [AW:0]              len_q, len_cur;
  logic                     accept, issue, done_nx;
  logic [SIZE-1:0][AW-1:0]  addr_q;

  // t has reached L+SIZE-1 once the last slot (t = L+SIZE-2) is issued
  assign t_end = TW'(len_q) + TW'(SIZE) - TW'(1);

  always_comb begin
    state_nx = state;
    t_cur    = t;
    base_cur = base_q;
    len_cur  = len_q;
    accept   = 1'b0;
    issue    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        // done high here means a zero-length tile just finished; a start in
        // that cycle is ignored
        if (start && !done) begin
          if (length == '0) begin
            done_nx = 1'b1;
          end else begin
            // slot t=0 is issued on the accepting edge so enb[0] rises in
            // the very next cycle; the lanes see the live inputs
            accept   = 1'b1;
            t_cur    = '0;
            base_cur = base_addr;
            len_cur  = length;
            issue    = !pause;
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (t == t_end) begin
          state_nx = DRAIN;
          done_nx  = 1'b1;
        end else begin
          issue = !pause;
        end
      end
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    t_nx = (state_nx == IDLE) ? '0 : t_cur + TW'(issue);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      t      <= '0;
      base_q <= '0;
      len_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      t     <= t_nx;
      if (accept) begin
        base_q <= base_addr;
        len_q  <= length;
      end
      busy <= (state_nx != IDLE);
      done <= done_nx;
    end
  end

  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    tile_lane_skew #(.AW(AW), .TW(TW), .LANE(k)) u_lane (
      .clock      (clock),
      .reset_n    (reset_n),
      .issue      (issue),
      .t          (t_cur),
      .base       (base_cur),
      .len        (len_cur),
      .enb        (enb[k]),
      .addr       (addr_q[k]),
      .lane_valid (lane_valid[k])
    );
  end

  assign addrb = addr_q;

endmodule

// File: tb/tb_tile_read_sequencer.sv
// Bench for tile_read_sequencer. The reference model lays out issue slots
// over calendar cycles: slot j (t=j) lands in the j-th non-paused cycle after
// start, and lane k reads row j-k when that row is inside the tile.
module tb_tile_read_sequencer;
  localparam int SIZE = 8;
  localparam int AW   = 10;
  localparam int MAXC = 1200;

  logic                clock = 1'b0;
  logic                reset_n, start, pause;
  logic [AW-1:0]       base_addr;
  logic [AW:0]         length;
  logic [SIZE-1:0]     enb, lane_valid;
  logic [SIZE*AW-1:0]  addrb;
  logic                busy, done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  tile_read_sequencer #(.SIZE(SIZE), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .pause(pause), .enb(enb), .addrb(addrb),
    .lane_valid(lane_valid), .busy(busy), .done(done)
  );

  // expected per cycle; inputs driven in cycle c are sampled at the edge
  // that opens cycle c+1
  logic [SIZE-1:0] e_enb [MAXC];
  logic [SIZE-1:0] e_lv  [MAXC];
  logic [AW-1:0]   e_addr[MAXC][SIZE];
  bit              e_busy[MAXC], e_done[MAXC];
  bit              pm[MAXC], sm[MAXC];

  int              done_seen, enb_pulses, lane0_n;
  logic [AW-1:0]   lane0_seen[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build(input logic [AW-1:0] b, input int len, input int abort_c,
                       output int ncyc, output int done_c);
    int j, c;
    for (int i = 0; i < MAXC; i++) begin
      e_enb[i] = '0; e_lv[i] = '0; e_busy[i] = 0; e_done[i] = 0;
      for (int k = 0; k < SIZE; k++) e_addr[i][k] = '0;
    end
    if (len == 0) begin
      done_c = 1;
      e_done[1] = 1;
    end else begin
      j = 0; c = 1;
      while (j <= len + SIZE - 2) begin
        if (!pm[c-1]) begin
          for (int k = 0; k < SIZE; k++)
            if (j - k >= 0 && j - k < len) begin
              e_enb[c][k]  = 1'b1;
              e_addr[c][k] = AW'(int'(b) + j - k);
            end
          j++;
        end
        c++;
      end
      done_c = c;
      e_done[c] = 1;
      for (int i = 1; i <= c; i++) e_busy[i] = 1;
    end
    for (int i = 1; i < MAXC; i++) e_lv[i] = e_enb[i-1];
    if (abort_c >= 0)
      for (int i = abort_c + 1; i < MAXC; i++) begin
        e_enb[i] = '0; e_lv[i] = '0; e_busy[i] = 0; e_done[i] = 0;
      end
    ncyc = done_c + 4;
    if (abort_c >= 0 && ncyc < abort_c + 12) ncyc = abort_c + 12;
  endtask

  // called just after a rising edge with the DUT idle; start goes in cycle 0
  task automatic run_tile(input string nm, input logic [AW-1:0] b, input int len,
                          input int abort_c, input bit extra_starts);
    int ncyc, done_c;
    build(b, len, abort_c, ncyc, done_c);
    for (int i = 0; i < MAXC; i++) sm[i] = 0;
    if (extra_starts && abort_c < 0) begin
      for (int i = 1; i <= done_c; i++) sm[i] = ($urandom_range(0, 2) == 0);
      sm[done_c] = 1;
    end
    done_seen = -1; enb_pulses = 0; lane0_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      start     = (c == 0) || sm[c];
      base_addr = (c == 0) ? b : AW'($urandom);
      length    = (c == 0) ? (AW+1)'(len) : (AW+1)'($urandom_range(1, 40));
      pause     = pm[c];
      reset_n   = (c != abort_c);
      @(negedge clock);
      check($sformatf("%s c%0d enb", nm, c), 64'(enb), 64'(e_enb[c]));
      check($sformatf("%s c%0d lane_valid", nm, c), 64'(lane_valid), 64'(e_lv[c]));
      check($sformatf("%s c%0d busy", nm, c), 64'(busy), 64'(e_busy[c]));
      check($sformatf("%s c%0d done", nm, c), 64'(done), 64'(e_done[c]));
      for (int k = 0; k < SIZE; k++)
        if (e_enb[c][k])
          check($sformatf("%s c%0d addr%0d", nm, c, k), 64'(addrb[k*AW +: AW]), 64'(e_addr[c][k]));
      if (done === 1'b1 && done_seen < 0) done_seen = c;
      enb_pulses += $countones(enb);
      if (enb[0] === 1'b1 && lane0_n < 4) begin
        lane0_seen[lane0_n] = addrb[AW-1:0];
        lane0_n++;
      end
      @(posedge clock); #1;
    end
    start = 0; pause = 0; reset_n = 1;
    if (abort_c < 0) check($sformatf("%s enb_pulses", nm), 64'(enb_pulses), 64'(len * SIZE));
  endtask

  task automatic clear_pause();
    for (int i = 0; i < MAXC; i++) pm[i] = 0;
  endtask

  initial begin
    logic [AW-1:0] wrap_exp[4];
    wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;

    // reset held 3 cycles with start/pause asserted: reset wins
    reset_n = 0; start = 1; pause = 1; base_addr = '1; length = 11'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); @(negedge clock);
      check("rst enb", 64'(enb), 64'd0);
      check("rst addrb", 64'(addrb), 64'd0);
      check("rst lane_valid", 64'(lane_valid), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
    end
    @(posedge clock); #1;
    reset_n = 1; start = 0; pause = 0;
    @(negedge clock);
    check("idle busy", 64'(busy), 64'd0);
    check("idle enb", 64'(enb), 64'd0);
    @(posedge clock); #1;

    clear_pause();
    run_tile("basic", 10'h010, 4, -1, 0);
    check("basic done cycle", 64'(done_seen), 64'd12);
    for (int i = 0; i < 4; i++)
      check($sformatf("basic lane0 addr%0d", i), 64'(lane0_seen[i]), 64'(10'h010 + i));

    run_tile("wrap", 10'h3FE, 4, -1, 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap lane0 addr%0d", i), 64'(lane0_seen[i]), 64'(wrap_exp[i]));

    // pause sampled at the edges opening cycles 3 and 4
    pm[2] = 1; pm[3] = 1;
    run_tile("pause", 10'h010, 4, -1, 0);
    check("pause done cycle", 64'(done_seen), 64'd14);
    clear_pause();

    run_tile("zero", 10'h123, 0, -1, 1);
    check("zero done cycle", 64'(done_seen), 64'd1);

    run_tile("busystart", 10'h010, 4, -1, 1);
    check("busystart done cycle", 64'(done_seen), 64'd12);

    run_tile("abort", 10'h200, 16, 5, 0);
    check("abort no done", 64'(done_seen), 64'hFFFF_FFFF_FFFF_FFFF);
    run_tile("post_abort", 10'h010, 4, -1, 0);
    check("post_abort done cycle", 64'(done_seen), 64'd12);

    run_tile("maxlen", 10'h0FF, 1024, -1, 0);
    check("maxlen done cycle", 64'(done_seen), 64'(1024 + SIZE));

    for (int n = 0; n < 30; n++) begin
      clear_pause();
      for (int i = 0; i < 40; i++) pm[i] = ($urandom_range(0, 3) == 0);
      run_tile($sformatf("rand%0d", n), AW'($urandom), int'($urandom_range(0, 20)), -1,
               bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
